// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared definitions for the 5-stage pipeline sequencing controller:
// forwarding-select codes, FSM state encoding and special register numbers.
package pipeline_hazard_ctrl_pkg;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_EX  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b11;

  localparam logic [3:0] REG_PC = 4'hF;

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } state_t;

  // True when an enabled producer writes the register being read.
  function automatic logic reg_match(input logic en, input logic [3:0] prod, input logic [3:0] r);
    return en && (prod == r);
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-controller bus: pipeline register fields flowing in from the
// datapath and the sequencing/forwarding controls flowing back out.
interface pipeline_hazard_ctrl_if;

  logic [3:0] id_ra;
  logic [3:0] id_rb;
  logic [3:0] id_rd;
  logic       id_use_a;
  logic       id_use_b;
  logic       id_use_d;
  logic [3:0] ex_rd;
  logic       ex_rf_en;
  logic       ex_load;
  logic [3:0] mem_rd;
  logic       mem_rf_en;
  logic [3:0] wb_rd;
  logic       wb_rf_en;
  logic       branch_taken;

  logic       pc_le;
  logic       ifid_le;
  logic       cu_mux_s;
  logic       ifid_flush;
  logic [1:0] fwd_a;
  logic [1:0] fwd_b;
  logic [1:0] fwd_d;

  modport master (
    output id_ra, id_rb, id_rd, id_use_a, id_use_b, id_use_d,
           ex_rd, ex_rf_en, ex_load, mem_rd, mem_rf_en,
           wb_rd, wb_rf_en, branch_taken,
    input  pc_le, ifid_le, cu_mux_s, ifid_flush, fwd_a, fwd_b, fwd_d
  );

  modport slave (
    input  id_ra, id_rb, id_rd, id_use_a, id_use_b, id_use_d,
           ex_rd, ex_rf_en, ex_load, mem_rd, mem_rf_en,
           wb_rd, wb_rf_en, branch_taken,
    output pc_le, ifid_le, cu_mux_s, ifid_flush, fwd_a, fwd_b, fwd_d
  );

endinterface

// File: rtl/pipeline_hazard_ctrl_fwd_select.sv
// Operand forwarding select for one ID-stage operand mux. The youngest
// producer wins (EX > MEM > WB); a load in EX has no result yet, and the
// PC register is never forwarded.
module pipeline_hazard_ctrl_fwd_select
  import pipeline_hazard_ctrl_pkg::*;
(
  input  logic       use_op,
  input  logic [3:0] r,
  input  logic [3:0] ex_rd,
  input  logic       ex_rf_en,
  input  logic       ex_load,
  input  logic [3:0] mem_rd,
  input  logic       mem_rf_en,
  input  logic [3:0] wb_rd,
  input  logic       wb_rf_en,
  output logic [1:0] sel
);

  // Priority chain choosing the freshest copy of register r.
  always_comb begin
    sel = FWD_RF;
    if (!use_op || r == REG_PC) begin
      sel = FWD_RF;
    end else if (reg_match(ex_rf_en && !ex_load, ex_rd, r)) begin
      sel = FWD_EX;
    end else if (reg_match(mem_rf_en, mem_rd, r)) begin
      sel = FWD_MEM;
    end else if (reg_match(wb_rf_en, wb_rd, r)) begin
      sel = FWD_WB;
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Sequencing controller for the 5-stage pipeline: boot-time bubble
// injection, load-use stall, taken-branch flush, operand forwarding and
// saturating stall/flush event counters.
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int BOOT_CYCLES = 8,
  parameter int CNT_W       = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  pipeline_hazard_ctrl_if.slave hz,
  output logic [CNT_W-1:0]     stall_cnt,
  output logic [CNT_W-1:0]     flush_cnt,
  output logic                 booting
);

  // A zero-length boot makes no sense; it behaves as a single cycle.
  localparam int BOOT_EFF = (BOOT_CYCLES < 1) ? 1 : BOOT_CYCLES;
  localparam int BW       = (BOOT_EFF > 1) ? $clog2(BOOT_EFF) : 1;
  localparam logic [BW-1:0] BOOT_LAST = BW'(BOOT_EFF - 1);

  state_t        state;
  state_t        state_next;
  logic [BW-1:0] boot_cnt;
  logic [BW-1:0] boot_next;
  logic          load_use;
  logic          stall_inc;
  logic          flush_inc;
  logic          pc_le;
  logic          ifid_le;
  logic          cu_mux_s;
  logic          ifid_flush;

  assign load_use = hz.ex_load && hz.ex_rf_en &&
                    ((hz.id_use_a && hz.ex_rd == hz.id_ra) ||
                     (hz.id_use_b && hz.ex_rd == hz.id_rb) ||
                     (hz.id_use_d && hz.ex_rd == hz.id_rd));

  // State, boot counter and event counters; reset drops everything in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= BOOT;
      boot_cnt  <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      state    <= state_next;
      boot_cnt <= boot_next;
      if (stall_inc && stall_cnt != '1) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
      if (flush_inc && flush_cnt != '1) begin
        flush_cnt <= flush_cnt + 1'b1;
      end
    end
  end

  // Next state and Mealy controls; a stall beats a flush so the branch is
  // re-resolved once its operands are valid.
  always_comb begin
    state_next = state;
    boot_next  = boot_cnt;
    pc_le      = 1'b1;
    ifid_le    = 1'b1;
    cu_mux_s   = 1'b0;
    ifid_flush = 1'b0;
    booting    = 1'b0;
    stall_inc  = 1'b0;
    flush_inc  = 1'b0;
    case (state)
      BOOT: begin
        booting = 1'b1;
        if (boot_cnt == BOOT_LAST) begin
          state_next = RUN;
          boot_next  = '0;
        end else begin
          boot_next = boot_cnt + BW'(1);
        end
      end
      RUN: begin
        if (load_use) begin
          pc_le     = 1'b0;
          ifid_le   = 1'b0;
          cu_mux_s  = 1'b0;
          stall_inc = 1'b1;
        end else if (hz.branch_taken) begin
          cu_mux_s   = 1'b1;
          ifid_flush = 1'b1;
          flush_inc  = 1'b1;
        end else begin
          cu_mux_s = 1'b1;
        end
      end
      default: begin
        state_next = BOOT;
        boot_next  = '0;
      end
    endcase
  end

  assign hz.pc_le      = pc_le;
  assign hz.ifid_le    = ifid_le;
  assign hz.cu_mux_s   = cu_mux_s;
  assign hz.ifid_flush = ifid_flush;

  pipeline_hazard_ctrl_fwd_select u_fwd_a (
    .use_op    (hz.id_use_a),
    .r         (hz.id_ra),
    .ex_rd     (hz.ex_rd),
    .ex_rf_en  (hz.ex_rf_en),
    .ex_load   (hz.ex_load),
    .mem_rd    (hz.mem_rd),
    .mem_rf_en (hz.mem_rf_en),
    .wb_rd     (hz.wb_rd),
    .wb_rf_en  (hz.wb_rf_en),
    .sel       (hz.fwd_a)
  );

  pipeline_hazard_ctrl_fwd_select u_fwd_b (
    .use_op    (hz.id_use_b),
    .r         (hz.id_rb),
    .ex_rd     (hz.ex_rd),
    .ex_rf_en  (hz.ex_rf_en),
    .ex_load   (hz.ex_load),
    .mem_rd    (hz.mem_rd),
    .mem_rf_en (hz.mem_rf_en),
    .wb_rd     (hz.wb_rd),
    .wb_rf_en  (hz.wb_rf_en),
    .sel       (hz.fwd_b)
  );

  pipeline_hazard_ctrl_fwd_select u_fwd_d (
    .use_op    (hz.id_use_d),
    .r         (hz.id_rd),
    .ex_rd     (hz.ex_rd),
    .ex_rf_en  (hz.ex_rf_en),
    .ex_load   (hz.ex_load),
    .mem_rd    (hz.mem_rd),
    .mem_rf_en (hz.mem_rf_en),
    .wb_rd     (hz.wb_rd),
    .wb_rf_en  (hz.wb_rf_en),
    .sel       (hz.fwd_d)
  );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed, table-driven bench for the pipeline hazard controller, plus
// hand-written boot, reset-mid-stall and counter-saturation sequences.
module tb_pipeline_hazard_ctrl;

  localparam int BOOT_CYCLES = 8;
  localparam int CNT_W       = 4;

  localparam logic [3:0] C_RUN   = 4'b1110;
  localparam logic [3:0] C_STALL = 4'b0000;
  localparam logic [3:0] C_FLUSH = 4'b1111;

  typedef struct {
    logic [3:0] ra, rb, rd;
    logic       ua, ub, ud;
    logic [3:0] ex_rd;
    logic       ex_en, ex_ld;
    logic [3:0] mem_rd;
    logic       mem_en;
    logic [3:0] wb_rd;
    logic       wb_en;
    logic       br;
    logic [3:0] ctrl;
    logic [1:0] fa, fb, fd;
  } vec_t;

  logic clk;
  logic rst;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;
  logic booting;

  int errors = 0;
  int checks = 0;

  vec_t vecs[15];

  pipeline_hazard_ctrl_if hz ();

  pipeline_hazard_ctrl #(
    .BOOT_CYCLES (BOOT_CYCLES),
    .CNT_W       (CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .hz        (hz),
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt),
    .booting   (booting)
  );

  // Free-running clock, 10 time-unit period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(
    input logic [3:0] ra, input logic [3:0] rb, input logic [3:0] rd,
    input logic ua, input logic ub, input logic ud,
    input logic [3:0] ex_rd, input logic ex_en, input logic ex_ld,
    input logic [3:0] mem_rd, input logic mem_en,
    input logic [3:0] wb_rd, input logic wb_en, input logic br,
    input logic [3:0] ctrl, input logic [1:0] fa, input logic [1:0] fb, input logic [1:0] fd);
    vec_t v;
    v.ra = ra; v.rb = rb; v.rd = rd;
    v.ua = ua; v.ub = ub; v.ud = ud;
    v.ex_rd = ex_rd; v.ex_en = ex_en; v.ex_ld = ex_ld;
    v.mem_rd = mem_rd; v.mem_en = mem_en;
    v.wb_rd = wb_rd; v.wb_en = wb_en; v.br = br;
    v.ctrl = ctrl; v.fa = fa; v.fb = fb; v.fd = fd;
    return v;
  endfunction

  function automatic int sat(input int val);
    return (val > 15) ? 15 : val;
  endfunction

  task automatic applyStimulus(input vec_t v);
    hz.id_ra        = v.ra;
    hz.id_rb        = v.rb;
    hz.id_rd        = v.rd;
    hz.id_use_a     = v.ua;
    hz.id_use_b     = v.ub;
    hz.id_use_d     = v.ud;
    hz.ex_rd        = v.ex_rd;
    hz.ex_rf_en     = v.ex_en;
    hz.ex_load      = v.ex_ld;
    hz.mem_rd       = v.mem_rd;
    hz.mem_rf_en    = v.mem_en;
    hz.wb_rd        = v.wb_rd;
    hz.wb_rf_en     = v.wb_en;
    hz.branch_taken = v.br;
  endtask

  task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int exp_stall;
    int exp_flush;
    logic [3:0] ctrl_now;

    //            ra rb rd  ua ub ud ex ee el  mr me  wr we br  ctrl     fa     fb     fd
    vecs[0]  = mk(0, 0, 0,  0, 0, 0, 0, 0, 0,  0, 0,  0, 0, 0,  C_RUN,   2'b00, 2'b00, 2'b00);
    vecs[1]  = mk(3, 0, 0,  1, 0, 0, 3, 1, 1,  0, 0,  0, 0, 0,  C_STALL, 2'b00, 2'b00, 2'b00);
    vecs[2]  = mk(3, 0, 0,  1, 0, 0, 0, 0, 0,  3, 1,  0, 0, 0,  C_RUN,   2'b10, 2'b00, 2'b00);
    vecs[3]  = mk(0, 5, 0,  0, 1, 0, 5, 1, 0,  5, 1,  5, 1, 0,  C_RUN,   2'b00, 2'b01, 2'b00);
    vecs[4]  = mk(0, 5, 0,  0, 1, 0, 5, 0, 0,  5, 1,  5, 1, 0,  C_RUN,   2'b00, 2'b10, 2'b00);
    vecs[5]  = mk(0, 5, 0,  0, 1, 0, 5, 0, 0,  5, 0,  5, 1, 0,  C_RUN,   2'b00, 2'b11, 2'b00);
    vecs[6]  = mk(0, 15,0,  0, 1, 0, 15,1, 0,  15,1,  15,1, 0,  C_RUN,   2'b00, 2'b00, 2'b00);
    vecs[7]  = mk(0, 0, 0,  0, 0, 0, 0, 0, 0,  0, 0,  0, 0, 1,  C_FLUSH, 2'b00, 2'b00, 2'b00);
    vecs[8]  = mk(0, 7, 0,  0, 1, 0, 7, 1, 1,  0, 0,  0, 0, 1,  C_STALL, 2'b00, 2'b00, 2'b00);
    vecs[9]  = mk(0, 0, 9,  0, 0, 1, 9, 1, 1,  0, 0,  9, 1, 0,  C_STALL, 2'b00, 2'b00, 2'b11);
    vecs[10] = mk(4, 0, 0,  0, 0, 0, 4, 1, 1,  0, 0,  0, 0, 0,  C_RUN,   2'b00, 2'b00, 2'b00);
    vecs[11] = mk(4, 0, 0,  1, 0, 0, 4, 0, 1,  0, 0,  0, 0, 0,  C_RUN,   2'b00, 2'b00, 2'b00);
    vecs[12] = mk(6, 0, 6,  1, 0, 1, 6, 1, 0,  6, 1,  0, 0, 0,  C_RUN,   2'b01, 2'b00, 2'b01);
    vecs[13] = mk(0, 0, 0,  0, 0, 0, 0, 0, 0,  2, 1,  0, 0, 1,  C_FLUSH, 2'b00, 2'b00, 2'b00);
    vecs[14] = mk(2, 0, 0,  1, 0, 0, 0, 0, 0,  2, 1,  0, 0, 1,  C_FLUSH, 2'b10, 2'b00, 2'b00);

    // Reset with a branch pending: it must be ignored throughout boot.
    rst = 1'b1;
    applyStimulus(vecs[7]);
    #2;
    checkOutput("reset_booting", 16'(booting), 16'd1);
    checkOutput("reset_cu_mux_s", 16'(hz.cu_mux_s), 16'd0);
    checkOutput("reset_pc_ifid_le", 16'({hz.pc_le, hz.ifid_le}), 16'b11);
    checkOutput("reset_ifid_flush", 16'(hz.ifid_flush), 16'd0);
    checkOutput("reset_stall_cnt", 16'(stall_cnt), 16'd0);
    #1 rst = 1'b0;

    for (int e = 1; e <= BOOT_CYCLES; e++) begin
      tick();
      if (e < BOOT_CYCLES) begin
        checkOutput($sformatf("boot%0d_booting", e), 16'(booting), 16'd1);
        checkOutput($sformatf("boot%0d_ctrl", e),
                    16'({hz.pc_le, hz.ifid_le, hz.cu_mux_s, hz.ifid_flush}), 16'b1100);
      end else begin
        checkOutput("boot_done_booting", 16'(booting), 16'd0);
        checkOutput("boot_done_ctrl",
                    16'({hz.pc_le, hz.ifid_le, hz.cu_mux_s, hz.ifid_flush}), 16'(C_FLUSH));
      end
    end
    checkOutput("boot_flush_cnt", 16'(flush_cnt), 16'd0);

    // Table-driven RUN vectors with running counter model.
    exp_stall = 0;
    exp_flush = 0;
    for (int i = 0; i < 15; i++) begin
      applyStimulus(vecs[i]);
      #1;
      ctrl_now = {hz.pc_le, hz.ifid_le, hz.cu_mux_s, hz.ifid_flush};
      checkOutput($sformatf("vec%0d_ctrl", i), 16'(ctrl_now), 16'(vecs[i].ctrl));
      checkOutput($sformatf("vec%0d_fwd_a", i), 16'(hz.fwd_a), 16'(vecs[i].fa));
      checkOutput($sformatf("vec%0d_fwd_b", i), 16'(hz.fwd_b), 16'(vecs[i].fb));
      checkOutput($sformatf("vec%0d_fwd_d", i), 16'(hz.fwd_d), 16'(vecs[i].fd));
      checkOutput($sformatf("vec%0d_booting", i), 16'(booting), 16'd0);
      if (vecs[i].ctrl == C_STALL) exp_stall = sat(exp_stall + 1);
      if (vecs[i].ctrl == C_FLUSH) exp_flush = sat(exp_flush + 1);
      tick();
      checkOutput($sformatf("vec%0d_stall_cnt", i), 16'(stall_cnt), 16'(exp_stall));
      checkOutput($sformatf("vec%0d_flush_cnt", i), 16'(flush_cnt), 16'(exp_flush));
    end

    // Reset asserted asynchronously while a load-use stall is active.
    applyStimulus(vecs[1]);
    #1;
    checkOutput("pre_reset_stall_pc_le", 16'(hz.pc_le), 16'd0);
    #2 rst = 1'b1;
    #1;
    checkOutput("async_reset_booting", 16'(booting), 16'd1);
    checkOutput("async_reset_ctrl",
                16'({hz.pc_le, hz.ifid_le, hz.cu_mux_s, hz.ifid_flush}), 16'b1100);
    checkOutput("async_reset_stall_cnt", 16'(stall_cnt), 16'd0);
    checkOutput("async_reset_flush_cnt", 16'(flush_cnt), 16'd0);
    #2 rst = 1'b0;

    for (int e = 1; e <= BOOT_CYCLES; e++) begin
      tick();
      if (e < BOOT_CYCLES) begin
        checkOutput($sformatf("reboot%0d_booting", e), 16'(booting), 16'd1);
        checkOutput($sformatf("reboot%0d_ctrl", e),
                    16'({hz.pc_le, hz.ifid_le, hz.cu_mux_s, hz.ifid_flush}), 16'b1100);
        checkOutput($sformatf("reboot%0d_stall_cnt", e), 16'(stall_cnt), 16'd0);
      end else begin
        checkOutput("reboot_done_booting", 16'(booting), 16'd0);
        checkOutput("reboot_done_ctrl",
                    16'({hz.pc_le, hz.ifid_le, hz.cu_mux_s, hz.ifid_flush}), 16'(C_STALL));
        checkOutput("reboot_done_stall_cnt", 16'(stall_cnt), 16'd0);
      end
    end

    // Continuous load-use with a branch also pending: counter saturates,
    // and no flush is ever taken.
    hz.branch_taken = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      checkOutput($sformatf("sat%0d_stall_cnt", k), 16'(stall_cnt), 16'(sat(k)));
      checkOutput($sformatf("sat%0d_ifid_flush", k), 16'(hz.ifid_flush), 16'd0);
    end
    checkOutput("sat_flush_cnt", 16'(flush_cnt), 16'd0);
    checkOutput("sat_pc_le", 16'(hz.pc_le), 16'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Sequencing controller for the 5-stage pipeline: PC, IF/ID, ID/EXE, EXE/MEM and MEM/WB registers.
- Generates the PC and IF/ID load enables, the cuMux select `s`, the IF/ID flush, and operand-forwarding selects for the ID-stage operand muxes.
- Runs a post-reset boot sequence that feeds bubbles while the pipeline fills, detects load-use hazards and taken-branch flushes, and keeps saturating event counters.

Parameters:
- BOOT_CYCLES, 8, number of cycles after reset during which cuMux injects NOPs (cu_mux_s=0).
- CNT_W, 16, width of the stall and flush event counters.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- id_ra, id_rb, id_rd  in  4 each  ID-stage source register fields; id_rd is the store-data source.
- id_use_a, id_use_b, id_use_d  in  1 each  the ID instruction actually reads that operand.
- ex_rd  in  4  destination register in the ID/EXE output.
- ex_rf_en, ex_load  in  1 each  EX instruction writes the register file / is a load.
- mem_rd  in  4;  mem_rf_en  in  1  EXE/MEM destination and write enable.
- wb_rd  in  4;  wb_rf_en  in  1  MEM/WB destination and write enable.
- branch_taken  in  1  ID-stage condition handler resolved a taken branch.
- pc_le  out  1  PC load enable.
- ifid_le  out  1  IF/ID load enable.
- cu_mux_s  out  1  1 passes Control Unit signals; 0 forces all-zero NOP controls.
- ifid_flush  out  1  clears IF/ID on the next edge.
- fwd_a, fwd_b, fwd_d  out  2 each  operand mux select: 00 register file, 01 EX result, 10 MEM result, 11 WB data.
- stall_cnt, flush_cnt  out  CNT_W each  saturating event counters.
- booting  out  1  high while in BOOT.

Behaviour:
- FSM states: BOOT, RUN.
  - Asynchronous reset forces BOOT, boot counter = 0, both event counters = 0.
  - Reset may assert mid-operation; it abandons any stall or flush immediately.
- BOOT:
  - Outputs: pc_le=1, ifid_le=1, cu_mux_s=0, ifid_flush=0, booting=1.
  - Boot counter increments every cycle.
  - Transition to RUN on the edge where counter == BOOT_CYCLES-1.
  - Hazard and branch inputs are ignored. Counters do not count in BOOT.
  - BOOT_CYCLES=0 is illegal; treat it as 1.
- RUN, load-use hazard:
  - load_use = ex_load & ex_rf_en & ((id_use_a & ex_rd==id_ra) | (id_use_b & ex_rd==id_rb) | (id_use_d & ex_rd==id_rd)).
  - When load_use=1, in the same cycle (combinational, Mealy): pc_le=0, ifid_le=0, cu_mux_s=0, ifid_flush=0, and stall_cnt increments.
  - Exactly one bubble is inserted. The next cycle the load sits in MEM and is forwarded with select 10.
- RUN, taken branch (branch_taken=1 and load_use=0):
  - ifid_flush=1, pc_le=1, ifid_le=1, cu_mux_s=1; flush_cnt increments.
  - Each cycle with branch_taken high is an independent flush.
- Simultaneous load_use and branch_taken: the stall wins; no flush that cycle. The branch is re-evaluated on the next cycle once operands are valid.
- RUN, neither event: pc_le=1, ifid_le=1, cu_mux_s=1, ifid_flush=0, booting=0.
- Forwarding (combinational, independent of state, evaluated per operand X with register field r):
  - If ex_rf_en & ~ex_load & ex_rd==r → 01.
  - Else if mem_rf_en & mem_rd==r → 10.
  - Else if wb_rf_en & wb_rd==r → 11.
  - Else → 00.
  - EX > MEM > WB priority; the youngest producer wins.
  - Register 15 (PC) is never forwarded: r==4'hF → 00.
  - id_use_X=0 → 00.
  - A loading EX instruction never produces 01.
- Counters saturate at all-ones; they do not wrap.
- Reset values:
  - booting=1, cu_mux_s=0, pc_le=1, ifid_le=1, ifid_flush=0.
  - fwd_* = 00 unless the inputs dictate otherwise; stall_cnt=0, flush_cnt=0.

Decomposition:
- Shared pipeline package holds:
  - Forwarding-select constants: FWD_RF=2'b00, FWD_EX=2'b01, FWD_MEM=2'b10, FWD_WB=2'b11.
  - State encoding: BOOT=1'b0, RUN=1'b1.
  - Register-number constant REG_PC=4'hF.
- One natural sub-module, fwd_select: purely combinational, instantiated three times for operands a, b and d.
- The FSM, hazard detection and counters stay in the top module.

Test Plan:
- Boot: deassert rst at t=3 with BOOT_CYCLES=8 → cu_mux_s=0 and booting=1 for exactly 8 rising edges, then cu_mux_s=1 with pc_le=ifid_le=1 throughout.
- Load-use: in RUN with ex_load=1, ex_rf_en=1, ex_rd=3, id_ra=3, id_use_a=1 → pc_le=ifid_le=cu_mux_s=0 for one cycle and stall_cnt 0→1. Next cycle, with mem_rd=3, mem_rf_en=1, ex_load=0 → fwd_a=10 and no stall.
- Forward priority: ex_rd=mem_rd=wb_rd=5, all rf_en=1, ex_load=0, id_rb=5, id_use_b=1 → fwd_b=01. Drop ex_rf_en → 10. Drop mem_rf_en → 11. id_rb=15 → 00.
- Branch vs stall: branch_taken=1 alone → ifid_flush=1 and flush_cnt+1. Same cycle with a load_use condition → ifid_flush=0, stall asserted, flush_cnt unchanged.
- Reset mid-stall: assert rst asynchronously while load_use is active → booting=1 and cu_mux_s=0 immediately (before the next edge), stall_cnt=0, full 8-cycle boot repeats.
- Saturation: with CNT_W=4, apply 20 load-use cycles → stall_cnt holds 4'hF.
